// File: rtl/tim_pkg.sv
// rtl/tim_pkg.sv - register addresses and bit positions for the basic timer
package tim_pkg;

  localparam logic [3:0] ADDR_CR1  = 4'd0;
  localparam logic [3:0] ADDR_RSVD = 4'd1;
  localparam logic [3:0] ADDR_DIER = 4'd2;
  localparam logic [3:0] ADDR_SR   = 4'd3;
  localparam logic [3:0] ADDR_EGR  = 4'd4;
  localparam logic [3:0] ADDR_PSC  = 4'd5;
  localparam logic [3:0] ADDR_ARR  = 4'd6;
  localparam logic [3:0] ADDR_IDLE = 4'd7;

  localparam int CR1_CEN  = 0;
  localparam int CR1_OPM  = 3;
  localparam int CR1_DIR  = 4;
  localparam int CR1_ARPE = 7;
  localparam int DIER_UIE = 0;
  localparam int SR_UIF   = 0;
  localparam int EGR_UG   = 0;

endpackage

// File: rtl/tim_prescaler.sv
// rtl/tim_prescaler.sv - clock prescaler producing one count tick per PSC+1 cycles
module tim_prescaler #(
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);

  logic [PSC_W-1:0] psc_cnt;
  logic             at_top;

  assign at_top = (psc_cnt == psc);
  // A clear swallows any tick so a software update never double-counts.
  assign tick   = en && !clr && at_top;

  // Divider counter: clear has priority, freezes while disabled, wraps at psc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_cnt <= '0;
    end else if (clr) begin
      psc_cnt <= '0;
    end else if (en) begin
      psc_cnt <= at_top ? '0 : psc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tim_basic_gen.sv
// rtl/tim_basic_gen.sv - basic up/down timer with preloaded PSC/ARR and update flag
module tim_basic_gen #(
  parameter int CNT_W = 16,
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ld_tim_reg,
  input  logic [31:0]      data_reg,
  input  logic             ISR_rst,
  output logic             tim_uif,
  output logic             tim_irq,
  output logic [CNT_W-1:0] tim_cnt,
  output logic             tim_cen
);
  import tim_pkg::*;

  logic             cen, opm, dir, arpe, uie, uif;
  logic [PSC_W-1:0] psc_pre, psc_act;
  logic [CNT_W-1:0] arr_pre, arr_act, cnt;
  logic             wr_cr1, wr_dier, wr_sr, wr_psc, wr_arr;
  logic             ug, tick, cnt_upd, upd, uif_clr;
  logic             unused_data;

  assign wr_cr1  = (ld_tim_reg == ADDR_CR1);
  assign wr_dier = (ld_tim_reg == ADDR_DIER);
  assign wr_sr   = (ld_tim_reg == ADDR_SR);
  assign wr_psc  = (ld_tim_reg == ADDR_PSC);
  assign wr_arr  = (ld_tim_reg == ADDR_ARR);
  assign ug      = (ld_tim_reg == ADDR_EGR) && data_reg[EGR_UG];

  // Overflow in up mode, underflow in down mode; software UG is folded in for
  // the preload transfer and the flag, but does not trigger one-pulse stop.
  assign cnt_upd = tick && (dir ? (cnt == '0) : (cnt == arr_act));
  assign upd     = cnt_upd || ug;
  assign uif_clr = ISR_rst || (wr_sr && !data_reg[SR_UIF]);

  assign unused_data = ^data_reg;

  assign tim_uif = uif;
  assign tim_irq = uif && uie;
  assign tim_cnt = cnt;
  assign tim_cen = cen;

  tim_prescaler #(.PSC_W(PSC_W)) u_psc (
    .clk (clk),
    .rst (rst),
    .en  (cen),
    .clr (ug),
    .psc (psc_act),
    .tick(tick)
  );

  // Control register; a one-pulse stop overrides a same-edge CEN write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cen  <= 1'b0;
      opm  <= 1'b0;
      dir  <= 1'b0;
      arpe <= 1'b0;
    end else begin
      if (wr_cr1) begin
        cen  <= data_reg[CR1_CEN];
        opm  <= data_reg[CR1_OPM];
        dir  <= data_reg[CR1_DIR];
        arpe <= data_reg[CR1_ARPE];
      end
      if (cnt_upd && opm) begin
        cen <= 1'b0;
      end
    end
  end

  // Interrupt enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uie <= 1'b0;
    end else if (wr_dier) begin
      uie <= data_reg[DIER_UIE];
    end
  end

  // Update flag: setting beats clearing so an event is never dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uif <= 1'b0;
    end else if (upd) begin
      uif <= 1'b1;
    end else if (uif_clr) begin
      uif <= 1'b0;
    end
  end

  // Prescaler preload; the active value only changes on an update event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_pre <= '0;
      psc_act <= '0;
    end else begin
      if (wr_psc) begin
        psc_pre <= data_reg[PSC_W-1:0];
      end
      if (upd) begin
        psc_act <= psc_pre;
      end
    end
  end

  // Auto-reload: direct write when ARPE=0, otherwise staged until an update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arr_pre <= '1;
      arr_act <= '1;
    end else begin
      if (upd) begin
        arr_act <= arr_pre;
      end
      if (wr_arr) begin
        arr_pre <= data_reg[CNT_W-1:0];
        if (!arpe) begin
          arr_act <= data_reg[CNT_W-1:0];
        end
      end
    end
  end

  // Main counter; up mode wraps naturally past 2^CNT_W when ARR is below cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (ug) begin
      cnt <= dir ? arr_pre : '0;
    end else if (tick) begin
      if (dir) begin
        cnt <= (cnt == '0) ? arr_act : cnt - 1'b1;
      end else begin
        cnt <= (cnt == arr_act) ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tim_basic_gen.sv
// tb/tb_tim_basic_gen.sv - directed self-checking bench for tim_basic_gen
module tb_tim_basic_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ld_tim_reg = 4'd7;
  logic [31:0] data_reg = '0;
  logic        ISR_rst = 1'b0;
  logic        tim_uif, tim_irq, tim_cen;
  logic [15:0] tim_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int ecount = 0;

  typedef struct {
    logic [3:0]  ld;
    logic [31:0] data;
    logic        isr;
    logic        uif;
    logic        irq;
    logic [15:0] cnt;
    logic        cen;
  } vec_t;

  vec_t tbl [34];

  tim_basic_gen #(.CNT_W(16), .PSC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_tim_reg(ld_tim_reg),
    .data_reg  (data_reg),
    .ISR_rst   (ISR_rst),
    .tim_uif   (tim_uif),
    .tim_irq   (tim_irq),
    .tim_cnt   (tim_cnt),
    .tim_cen   (tim_cen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] ld, input logic [31:0] d, input logic isr);
    @(negedge clk);
    ld_tim_reg = ld;
    data_reg   = d;
    ISR_rst    = isr;
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic idle(input logic isr);
    step(4'd7, 32'd0, isr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ld_tim_reg = 4'd7;
    data_reg = '0;
    ISR_rst = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic u, input logic i,
                         input logic [15:0] c, input logic e);
    chk({tag, " uif"}, {31'd0, tim_uif}, {31'd0, u});
    chk({tag, " irq"}, {31'd0, tim_irq}, {31'd0, i});
    chk({tag, " cnt"}, {16'd0, tim_cnt}, {16'd0, c});
    chk({tag, " cen"}, {31'd0, tim_cen}, {31'd0, e});
  endtask

  // Step idle until tim_uif rises; report the edge index (ecount) or a timeout.
  task automatic wait_uif(input string tag, input int limit, output int at);
    int n;
    n = 0;
    at = -1;
    while (n < limit) begin
      idle(1'b0);
      n++;
      if (tim_uif) begin
        at = ecount;
        break;
      end
    end
    if (at < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: uif timeout after %0d cycles", tag, limit);
    end
  endtask

  initial begin
    int at;

    tbl[0]  = '{4'd6,  32'd5,        1'b0, 1'b0, 1'b0, 16'd0, 1'b0};
    tbl[1]  = '{4'd2,  32'd1,        1'b0, 1'b0, 1'b0, 16'd0, 1'b0};
    tbl[2]  = '{4'd0,  32'h11,       1'b0, 1'b0, 1'b0, 16'd0, 1'b1};
    tbl[3]  = '{4'd7,  32'd0,        1'b0, 1'b1, 1'b1, 16'd5, 1'b1};
    tbl[4]  = '{4'd7,  32'd0,        1'b0, 1'b1, 1'b1, 16'd4, 1'b1};
    tbl[5]  = '{4'd3,  32'd1,        1'b0, 1'b1, 1'b1, 16'd3, 1'b1};
    tbl[6]  = '{4'd3,  32'd0,        1'b0, 1'b0, 1'b0, 16'd2, 1'b1};
    tbl[7]  = '{4'd7,  32'd0,        1'b0, 1'b0, 1'b0, 16'd1, 1'b1};
    tbl[8]  = '{4'd7,  32'd0,        1'b0, 1'b0, 1'b0, 16'd0, 1'b1};
    tbl[9]  = '{4'd7,  32'd0,        1'b0, 1'b1, 1'b1, 16'd5, 1'b1};
    tbl[10] = '{4'd7,  32'd0,        1'b1, 1'b0, 1'b0, 16'd4, 1'b1};
    tbl[11] = '{4'd1,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 16'd3, 1'b1};
    tbl[12] = '{4'd7,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1};
    tbl[13] = '{4'd0,  32'h01,       1'b0, 1'b0, 1'b0, 16'd1, 1'b1};
    tbl[14] = '{4'd7,  32'd0,        1'b0, 1'b0, 1'b0, 16'd2, 1'b1};
    tbl[15] = '{4'd0,  32'd0,        1'b0, 1'b0, 1'b0, 16'd3, 1'b0};
    tbl[16] = '{4'd7,  32'd0,        1'b0, 1'b0, 1'b0, 16'd3, 1'b0};
    tbl[17] = '{4'd4,  32'd1,        1'b0, 1'b1, 1'b1, 16'd0, 1'b0};
    tbl[18] = '{4'd3,  32'd0,        1'b0, 1'b0, 1'b0, 16'd0, 1'b0};
    tbl[19] = '{4'd2,  32'd0,        1'b0, 1'b0, 1'b0, 16'd0, 1'b0};
    tbl[20] = '{4'd4,  32'd1,        1'b0, 1'b1, 1'b0, 16'd0, 1'b0};
    tbl[21] = '{4'd11, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0};
    tbl[22] = '{4'd4,  32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0};
    tbl[23] = '{4'd0,  32'h11,       1'b0, 1'b0, 1'b0, 16'd0, 1'b1};
    tbl[24] = '{4'd5,  32'd2,        1'b0, 1'b1, 1'b0, 16'd5, 1'b1};
    tbl[25] = '{4'd7,  32'd0,        1'b0, 1'b1, 1'b0, 16'd4, 1'b1};
    tbl[26] = '{4'd7,  32'd0,        1'b0, 1'b1, 1'b0, 16'd3, 1'b1};
    tbl[27] = '{4'd7,  32'd0,        1'b0, 1'b1, 1'b0, 16'd2, 1'b1};
    tbl[28] = '{4'd7,  32'd0,        1'b0, 1'b1, 1'b0, 16'd1, 1'b1};
    tbl[29] = '{4'd7,  32'd0,        1'b0, 1'b1, 1'b0, 16'd0, 1'b1};
    tbl[30] = '{4'd7,  32'd0,        1'b0, 1'b1, 1'b0, 16'd5, 1'b1};
    tbl[31] = '{4'd7,  32'd0,        1'b0, 1'b1, 1'b0, 16'd5, 1'b1};
    tbl[32] = '{4'd7,  32'd0,        1'b0, 1'b1, 1'b0, 16'd5, 1'b1};
    tbl[33] = '{4'd7,  32'd0,        1'b0, 1'b1, 1'b0, 16'd4, 1'b1};

    // Reset state.
    #2;
    chk_all("reset", 1'b0, 1'b0, 16'd0, 1'b0);
    do_reset();

    // Table: register map, down counting, flag clears, DIR change, UG, PSC preload.
    for (int i = 0; i < 34; i++) begin
      step(tbl[i].ld, tbl[i].data, tbl[i].isr);
      chk_all($sformatf("vec%0d", i), tbl[i].uif, tbl[i].irq, tbl[i].cnt, tbl[i].cen);
    end

    // Period (PSC+1)*(ARR+1)=22 with preloads, then ARPE change of ARR mid-period.
    do_reset();
    step(4'd5, 32'd1, 1'b0);
    step(4'd0, 32'h80, 1'b0);
    step(4'd6, 32'd10, 1'b0);
    step(4'd4, 32'd1, 1'b0);
    chk("ug uif", {31'd0, tim_uif}, 32'd1);
    step(4'd3, 32'd0, 1'b0);
    chk("ug clr", {31'd0, tim_uif}, 32'd0);
    step(4'd0, 32'h81, 1'b0);
    ecount = 0;
    wait_uif("per1", 40, at);
    chk("per1 edge", at, 22);
    idle(1'b1);
    chk("isr clr", {31'd0, tim_uif}, 32'd0);
    wait_uif("per2", 40, at);
    chk("per2 edge", at, 44);
    idle(1'b1);
    step(4'd6, 32'd4, 1'b0);
    wait_uif("arpe old", 40, at);
    chk("arpe old edge", at, 66);
    chk("arpe old cnt", {16'd0, tim_cnt}, 32'd0);
    idle(1'b1);
    wait_uif("arpe new", 40, at);
    chk("arpe new edge", at, 76);

    // One-pulse mode halts after a single update.
    do_reset();
    step(4'd6, 32'd3, 1'b0);
    step(4'd0, 32'h09, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    chk_all("opm pre", 1'b0, 1'b0, 16'd3, 1'b1);
    idle(1'b0);
    chk_all("opm upd", 1'b1, 1'b0, 16'd0, 1'b0);
    idle(1'b1);
    repeat (4) idle(1'b0);
    chk_all("opm hold", 1'b0, 1'b0, 16'd0, 1'b0);

    // Acknowledge held high across the update edge: set wins.
    do_reset();
    step(4'd2, 32'd1, 1'b0);
    step(4'd6, 32'd2, 1'b0);
    step(4'd0, 32'd1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk_all("setwin pre", 1'b0, 1'b0, 16'd2, 1'b1);
    idle(1'b1);
    chk_all("setwin", 1'b1, 1'b1, 16'd0, 1'b1);

    // ARR=0 updates every tick; SR clear on the same edge loses to the set.
    do_reset();
    step(4'd6, 32'd0, 1'b0);
    step(4'd0, 32'd1, 1'b0);
    idle(1'b0);
    chk_all("arr0 a", 1'b1, 1'b0, 16'd0, 1'b1);
    step(4'd3, 32'd0, 1'b0);
    chk_all("arr0 b", 1'b1, 1'b0, 16'd0, 1'b1);

    // Asynchronous reset mid-count, then stay idle until CEN is rewritten.
    do_reset();
    step(4'd6, 32'd20, 1'b0);
    step(4'd0, 32'd1, 1'b0);
    repeat (7) idle(1'b0);
    chk("pre rst cnt", {16'd0, tim_cnt}, 32'd7);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async rst", 1'b0, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) idle(1'b0);
    chk_all("post rst", 1'b0, 1'b0, 16'd0, 1'b0);
    step(4'd0, 32'd1, 1'b0);
    chk_all("recen", 1'b0, 1'b0, 16'd0, 1'b1);
    idle(1'b0);
    chk("recen cnt", {16'd0, tim_cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tim_basic_gen.md
TIM_BASIC_GEN -- requirements
Module: tim_basic_gen

Interface
REQ-001 Parameter CNT_W, default 16: counter and auto-reload width in bits (2..32).
REQ-002 Parameter PSC_W, default 16: prescaler width in bits (1..32).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ld_tim_reg  input  4  register select for a write this cycle; codes 7 and 8..15 are no-op (idle).
REQ-006 data_reg  input  32  write data; only the low bits defined per register are used, the rest are ignored.
REQ-007 ISR_rst  input  1  interrupt acknowledge; clears UIF.
REQ-008 tim_uif  output  1  update-event flag (sticky).
REQ-009 tim_irq  output  1  equals tim_uif AND UIE.
REQ-010 tim_cnt  output  CNT_W  current counter value.
REQ-011 tim_cen  output  1  current counter-enable bit.

Function
REQ-012 Register map: 0 CR1 (bit0 CEN, bit3 OPM, bit4 DIR with 0=up and 1=down, bit7 ARPE); 2 DIER (bit0 UIE); 3 SR (bit0 UIF); 4 EGR (bit0 UG); 5 PSC (PSC_W bits); 6 ARR (CNT_W bits); 1 reserved and treated as no-op.
REQ-013 A register write takes effect at the rising edge on which ld_tim_reg selects it.
REQ-014 PSC is always preloaded: the written value moves to the active prescaler only on an update event.
REQ-015 ARR with ARPE=0: the write updates the active ARR immediately.
REQ-016 ARR with ARPE=1: the write goes to the preload only and moves to the active ARR on an update event.
REQ-017 Prescaler: while CEN=1, psc_cnt counts 0..PSC_active; when psc_cnt equals PSC_active it wraps to 0 and issues one count tick.
REQ-018 Up mode (DIR=0): on a tick, if cnt equals ARR_active then cnt goes to 0 and an update event occurs; otherwise cnt increments by 1.
REQ-019 Down mode (DIR=1): on a tick, if cnt equals 0 then cnt goes to ARR_active and an update event occurs; otherwise cnt decrements by 1.
REQ-020 Update period is (PSC+1)*(ARR+1) clk cycles.
REQ-021 ARR=0 produces an update on every tick.
REQ-022 ARR written below the current cnt in up mode with ARPE=0: the counter wraps at 2^CNT_W and continues counting until it reaches ARR.
REQ-023 An update event sets UIF, transfers the PSC and ARR preloads to active, and, if OPM=1, clears CEN in the same edge so the counter halts at its reload value.
REQ-024 A UG write clears psc_cnt, sets cnt to 0 (up) or ARR_preload (down), performs the preload transfer and sets UIF, whether or not CEN=1.
REQ-025 UIF is cleared by ISR_rst=1 or by an SR write with bit0=0; an SR write with bit0=1 has no effect.
REQ-026 When UIF set and clear occur on the same edge, set wins so that no event is lost.
REQ-027 CEN=0 freezes psc_cnt and cnt; register writes are still accepted.
REQ-028 Changing DIR mid-count takes effect on the next tick, with no update generated.
REQ-029 A write to CR1 and an update event on the same edge: OPM's clear of CEN wins over the written CEN.
REQ-030 tim_irq is combinational from registered state, with zero latency from UIF.

Reset
REQ-031 On rst: CR1=0, DIER=0, UIF=0, psc_cnt=0, cnt=0, PSC preload and active=0, ARR preload and active all-ones.
REQ-032 Output values in reset: tim_uif=0, tim_irq=0, tim_cnt=0, tim_cen=0.
REQ-033 rst asserted mid-count aborts immediately with no update event; counting resumes only after CEN is rewritten.

Structure
REQ-034 Shared package tim_pkg holds the register address constants, the CR1/DIER/SR/EGR bit positions and the idle code 7.
REQ-035 The prescaler is a sub-module tim_prescaler (PSC_W; inputs en, clr, psc; output tick).
REQ-036 The top module holds the register file, counter, update logic and flag.

Verification
REQ-037 PSC=1, ARR=10, ARPE=1, CEN=1 up -> tim_uif first rises 22 clk after the CEN edge; ISR_rst clears it; next rise occurs 22 clk later.
REQ-038 DIR=1, PSC=0, ARR=5 -> tim_cnt sequence 0,5,4,3,2,1,0,5; update at each 0->5 transition.
REQ-039 OPM=1, PSC=0, ARR=3 -> exactly one update after 4 clk; tim_cen drops the same edge; tim_cnt holds at 0.
REQ-040 ARPE=1, ARR changed 10->4 mid-period -> current period still ends at 10; next period ends at 4.
REQ-041 UIE=1, ISR_rst held high on the update edge -> tim_uif=1 and tim_irq=1 after that edge (set wins).
REQ-042 rst pulse while cnt=7 -> all outputs 0 asynchronously; after release, no activity until CEN is written.
